// File: rtl/el2_lsu_trigger_hit_ctl.sv
// el2_lsu_trigger_hit_ctl
//   Post-processing of the LSU trigger matcher. Raw per-trigger matches from
//   the m stage are chained in pairs (0/1, 2/3, ...) and qualified. They are
//   then registered into the r stage and gated by flush_r. The qualified r-stage
//   hits drive a breakpoint-exception request, a debug-halt request handshake
//   with dec, and per-trigger sticky status that holds until dec acknowledges it.
//
// Parameters
//   NUM_TRIG  trigger count, must be even
//   CNT_W     width of each per-trigger hit counter
//
// Optional feature macro
//   LSU_TRIG_HITCNT_EN  when defined, builds one saturating hit counter per
//                       trigger. When undefined, lsu_trig_hitcnt is tied to 0.
//
// Ports
//   clk, rst             core clock, synchronous active-high reset
//   lsu_trigger_match_m  raw matches (m)
//   lsu_valid_m          valid non-DMA LSU op (m)
//   lsu_exc_m            LSU exception on the m op
//   flush_m / flush_r    kill the m / r stage op
//   trig_chain           even bit i chains trigger i with i+1
//   trig_action          1 = debug halt, 0 = breakpoint exception
//   dec_trig_hit_ack     clears sticky/counter i
//   dec_halt_ack         dec accepted the halt request
//   dec_halt_done        debug halt exited
//   lsu_trigger_hit_r    qualified hits (r)
//   lsu_trig_brkpt_r     breakpoint-exception request (r)
//   lsu_trig_halt_req    debug-halt request level
//   lsu_trig_sticky      sticky hit status
//   lsu_trig_hitcnt      packed hit counters, trigger i at [i*CNT_W +: CNT_W]
module el2_lsu_trigger_hit_ctl #(
  parameter int unsigned NUM_TRIG = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_TRIG-1:0]       lsu_trigger_match_m,
  input  logic                      lsu_valid_m,
  input  logic                      lsu_exc_m,
  input  logic                      flush_m,
  input  logic                      flush_r,
  input  logic [NUM_TRIG-1:0]       trig_chain,
  input  logic [NUM_TRIG-1:0]       trig_action,
  input  logic [NUM_TRIG-1:0]       dec_trig_hit_ack,
  input  logic                      dec_halt_ack,
  input  logic                      dec_halt_done,
  output logic [NUM_TRIG-1:0]       lsu_trigger_hit_r,
  output logic                      lsu_trig_brkpt_r,
  output logic                      lsu_trig_halt_req,
  output logic [NUM_TRIG-1:0]       lsu_trig_sticky,
  output logic [NUM_TRIG*CNT_W-1:0] lsu_trig_hitcnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HALTED = 2'd2
  } state_t;

  logic [NUM_TRIG-1:0] eff_m;
  logic [NUM_TRIG-1:0] q_m;
  logic [NUM_TRIG-1:0] hit_r;
  logic                halt_hit;
  state_t              state;

  // Odd chain bits carry no meaning; fold them into a sink.
  logic unused_chain_odd;
  always_comb begin
    unused_chain_odd = 1'b0;
    for (int unsigned k = 0; k < NUM_TRIG / 2; k++) begin
      unused_chain_odd = unused_chain_odd ^ trig_chain[2*k+1];
    end
  end

  // Pair chaining: an armed chain requires both halves of the pair to match,
  // and then reports the hit on both triggers.
  always_comb begin
    eff_m = lsu_trigger_match_m;
    for (int unsigned k = 0; k < NUM_TRIG / 2; k++) begin
      if (trig_chain[2*k]) begin
        eff_m[2*k]   = lsu_trigger_match_m[2*k] & lsu_trigger_match_m[2*k+1];
        eff_m[2*k+1] = lsu_trigger_match_m[2*k] & lsu_trigger_match_m[2*k+1];
      end
    end
  end

  assign q_m = eff_m & {NUM_TRIG{lsu_valid_m & ~flush_m & ~lsu_exc_m}};

  always_ff @(posedge clk) begin
    if (rst) hit_r <= '0;
    else     hit_r <= q_m;
  end

  assign lsu_trigger_hit_r = hit_r & ~{NUM_TRIG{flush_r}};
  assign lsu_trig_brkpt_r  = |(lsu_trigger_hit_r & ~trig_action);
  assign halt_hit          = |(lsu_trigger_hit_r & trig_action);

  // Set has priority over ack so a hit in the ack cycle is not lost.
  always_ff @(posedge clk) begin
    if (rst) lsu_trig_sticky <= '0;
    else     lsu_trig_sticky <= (lsu_trig_sticky & ~dec_trig_hit_ack) | lsu_trigger_hit_r;
  end

  // Halt handshake; the request is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      lsu_trig_halt_req <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (halt_hit) begin
            state             <= REQ;
            lsu_trig_halt_req <= 1'b1;
          end
        end
        REQ: begin
          if (dec_halt_ack) begin
            state             <= HALTED;
            lsu_trig_halt_req <= 1'b0;
          end
        end
        HALTED: begin
          if (dec_halt_done) state <= IDLE;
        end
        default: begin
          state             <= IDLE;
          lsu_trig_halt_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef LSU_TRIG_HITCNT_EN
  logic [CNT_W-1:0] hitcnt [NUM_TRIG];

  // Ack clears and wins over increment; increment saturates at all-ones.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_TRIG; i++) begin
      if (rst || dec_trig_hit_ack[i]) begin
        hitcnt[i] <= '0;
      end else if (lsu_trigger_hit_r[i] && (hitcnt[i] != '1)) begin
        hitcnt[i] <= hitcnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    lsu_trig_hitcnt = '0;
    for (int unsigned i = 0; i < NUM_TRIG; i++) begin
      lsu_trig_hitcnt[i*CNT_W +: CNT_W] = hitcnt[i];
    end
  end
`else
  assign lsu_trig_hitcnt = '0;
`endif

endmodule

// File: tb/tb_el2_lsu_trigger_hit_ctl.sv
// Self-checking bench for el2_lsu_trigger_hit_ctl (NUM_TRIG=4, CNT_W=16).
module tb_el2_lsu_trigger_hit_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  match_m, chain, action, hit_ack;
  logic        valid_m, exc_m, fl_m, fl_r, halt_ack, halt_done;
  logic [3:0]  hit_r_o, sticky_o;
  logic        brkpt_o, halt_req_o;
  logic [63:0] hitcnt_o;

  el2_lsu_trigger_hit_ctl #(.NUM_TRIG(4), .CNT_W(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .lsu_trigger_match_m (match_m),
    .lsu_valid_m         (valid_m),
    .lsu_exc_m           (exc_m),
    .flush_m             (fl_m),
    .flush_r             (fl_r),
    .trig_chain          (chain),
    .trig_action         (action),
    .dec_trig_hit_ack    (hit_ack),
    .dec_halt_ack        (halt_ack),
    .dec_halt_done       (halt_done),
    .lsu_trigger_hit_r   (hit_r_o),
    .lsu_trig_brkpt_r    (brkpt_o),
    .lsu_trig_halt_req   (halt_req_o),
    .lsu_trig_sticky     (sticky_o),
    .lsu_trig_hitcnt     (hitcnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, chk;
    logic [3:0] m;
    logic       v, exc, fm, fr;
    logic [3:0] ch, act, ack;
    logic       hack, hdone;
    logic [3:0] e_hit;
    logic       e_brk, e_halt;
    logic [3:0] e_sticky;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb[$];
  logic [15:0] cnt_model [4];
  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic c, input logic [3:0] m, input logic v,
                     input logic exc, input logic fm, input logic fr, input logic [3:0] ch,
                     input logic [3:0] act, input logic [3:0] ack, input logic hack,
                     input logic hdone, input logic [3:0] eh, input logic eb,
                     input logic ehl, input logic [3:0] es);
    vec_t t;
    t.rst = r; t.chk = c; t.m = m; t.v = v; t.exc = exc; t.fm = fm; t.fr = fr;
    t.ch = ch; t.act = act; t.ack = ack; t.hack = hack; t.hdone = hdone;
    t.e_hit = eh; t.e_brk = eb; t.e_halt = ehl; t.e_sticky = es;
    vecs.push_back(t);
  endtask

  // Reference chaining/qualification for four triggers, written out by pair.
  function automatic logic [3:0] ref_q(input logic [3:0] m, input logic [3:0] ch,
                                       input logic v, input logic exc, input logic fm);
    logic [3:0] e;
    e = m;
    if (ch[0]) begin e[0] = m[0] & m[1]; e[1] = m[0] & m[1]; end
    if (ch[2]) begin e[2] = m[2] & m[3]; e[3] = m[2] & m[3]; end
    return (v && !exc && !fm) ? e : 4'b0000;
  endfunction

  function automatic logic [63:0] cnt_packed();
    logic [63:0] p;
`ifdef LSU_TRIG_HITCNT_EN
    p = {cnt_model[3], cnt_model[2], cnt_model[1], cnt_model[0]};
`else
    p = '0;
`endif
    return p;
  endfunction

  task automatic idle_inputs();
    rst = 0; match_m = 0; valid_m = 0; exc_m = 0; fl_m = 0; fl_r = 0;
    chain = 0; action = 0; hit_ack = 0; halt_ack = 0; halt_done = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; idle_inputs(); rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 0;
  endtask

  initial begin
    logic [3:0] exp_sb;
    int lat;
    bit seen;
    for (int i = 0; i < 4; i++) cnt_model[i] = '0;
    idle_inputs();

    //  rst c m        v exc fm fr ch       act      ack      hk hd  hit      brk hlt sticky
    add(1, 0, 4'hF,    1, 0, 0, 0, 4'h0,    4'h0,    4'h0,    0, 0,  4'h0,    0, 0, 4'h0);
    add(1, 1, 4'hF,    1, 0, 0, 0, 4'h0,    4'h0,    4'h0,    0, 0,  4'h0,    0, 0, 4'h0);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'h0,    4'h0,    0, 0,  4'h0,    0, 0, 4'h0);
    add(0, 1, 4'b0100, 1, 0, 0, 0, 4'h0,    4'h0,    4'h0,    0, 0,  4'h0,    0, 0, 4'h0);
    add(0, 1, 4'h0,    1, 0, 0, 0, 4'h0,    4'h0,    4'h0,    0, 0,  4'b0100, 1, 0, 4'h0);
    add(0, 1, 4'b0001, 1, 0, 0, 0, 4'b0001, 4'h0,    4'h0,    0, 0,  4'h0,    0, 0, 4'b0100);
    add(0, 1, 4'b0011, 1, 0, 0, 0, 4'b0001, 4'h0,    4'h0,    0, 0,  4'h0,    0, 0, 4'b0100);
    add(0, 1, 4'h0,    1, 0, 0, 0, 4'b0001, 4'h0,    4'h0,    0, 0,  4'b0011, 1, 0, 4'b0100);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'h0,    4'hF,    0, 0,  4'h0,    0, 0, 4'b0111);
    add(0, 1, 4'b0010, 1, 0, 1, 0, 4'h0,    4'h0,    4'h0,    0, 0,  4'h0,    0, 0, 4'h0);
    add(0, 1, 4'b0010, 1, 1, 0, 0, 4'h0,    4'h0,    4'h0,    0, 0,  4'h0,    0, 0, 4'h0);
    add(0, 1, 4'b0010, 1, 0, 0, 0, 4'h0,    4'h0,    4'h0,    0, 0,  4'h0,    0, 0, 4'h0);
    add(0, 1, 4'h0,    0, 0, 0, 1, 4'h0,    4'h0,    4'h0,    0, 0,  4'h0,    0, 0, 4'h0);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'h0,    4'h0,    0, 0,  4'h0,    0, 0, 4'h0);
    add(0, 1, 4'b1000, 1, 0, 0, 0, 4'h0,    4'b1000, 4'h0,    0, 0,  4'h0,    0, 0, 4'h0);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'b1000, 4'h0,    0, 0,  4'b1000, 0, 0, 4'h0);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'b1000, 4'h0,    0, 0,  4'h0,    0, 1, 4'b1000);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'b1000, 4'h0,    0, 1,  4'h0,    0, 1, 4'b1000);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'b1000, 4'h0,    1, 0,  4'h0,    0, 1, 4'b1000);
    add(0, 1, 4'b1000, 1, 0, 0, 0, 4'h0,    4'b1000, 4'h0,    0, 0,  4'h0,    0, 0, 4'b1000);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'b1000, 4'b1000, 0, 0,  4'b1000, 0, 0, 4'b1000);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'b1000, 4'h0,    0, 1,  4'h0,    0, 0, 4'b1000);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'b1000, 4'h0,    1, 0,  4'h0,    0, 0, 4'b1000);
    add(0, 1, 4'b1000, 1, 0, 0, 0, 4'h0,    4'b1000, 4'h0,    0, 0,  4'h0,    0, 0, 4'b1000);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'b1000, 4'h0,    0, 0,  4'b1000, 0, 0, 4'b1000);
    add(0, 1, 4'h0,    0, 0, 0, 1, 4'h0,    4'b1000, 4'h0,    0, 0,  4'h0,    0, 1, 4'b1000);
    add(1, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'b1000, 4'h0,    0, 0,  4'h0,    0, 1, 4'b1000);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'h0,    4'h0,    0, 0,  4'h0,    0, 0, 4'h0);
    add(0, 1, 4'b0010, 1, 0, 0, 0, 4'h0,    4'h0,    4'h0,    0, 0,  4'h0,    0, 0, 4'h0);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'h0,    4'b0010, 0, 0,  4'b0010, 1, 0, 4'h0);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'h0,    4'h0,    0, 0,  4'h0,    0, 0, 4'b0010);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'h0,    4'b0010, 0, 0,  4'h0,    0, 0, 4'b0010);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'h0,    4'h0,    0, 0,  4'h0,    0, 0, 4'h0);
    add(0, 1, 4'b0011, 1, 0, 0, 0, 4'b0001, 4'b0010, 4'h0,    0, 0,  4'h0,    0, 0, 4'h0);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'b0001, 4'b0010, 4'h0,    0, 0,  4'b0011, 1, 0, 4'h0);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'b0010, 4'h0,    0, 0,  4'h0,    0, 1, 4'b0011);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'b0010, 4'h0,    1, 0,  4'h0,    0, 1, 4'b0011);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'b0010, 4'h0,    0, 1,  4'h0,    0, 0, 4'b0011);
    add(0, 1, 4'h0,    0, 0, 0, 0, 4'h0,    4'b0010, 4'h0,    0, 0,  4'h0,    0, 0, 4'b0011);

    foreach (vecs[r]) begin
      @(posedge clk); #1;
      rst = vecs[r].rst; match_m = vecs[r].m; valid_m = vecs[r].v; exc_m = vecs[r].exc;
      fl_m = vecs[r].fm; fl_r = vecs[r].fr; chain = vecs[r].ch; action = vecs[r].act;
      hit_ack = vecs[r].ack; halt_ack = vecs[r].hack; halt_done = vecs[r].hdone;
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_sb = sb.pop_front();
        check($sformatf("sb_hit_r[%0d]", r), 64'(hit_r_o), 64'(exp_sb & ~{4{vecs[r].fr}}));
      end
      sb.push_back(vecs[r].rst ? 4'h0 : ref_q(vecs[r].m, vecs[r].ch, vecs[r].v, vecs[r].exc, vecs[r].fm));
      if (vecs[r].chk) begin
        check($sformatf("hit_r[%0d]", r),    64'(hit_r_o),    64'(vecs[r].e_hit));
        check($sformatf("brkpt[%0d]", r),    64'(brkpt_o),    64'(vecs[r].e_brk));
        check($sformatf("halt_req[%0d]", r), 64'(halt_req_o), 64'(vecs[r].e_halt));
        check($sformatf("sticky[%0d]", r),   64'(sticky_o),   64'(vecs[r].e_sticky));
        check($sformatf("hitcnt[%0d]", r),   hitcnt_o,        cnt_packed());
      end
      for (int i = 0; i < 4; i++) begin
        if (vecs[r].rst || vecs[r].ack[i]) cnt_model[i] = '0;
        else if (vecs[r].e_hit[i] && cnt_model[i] != 16'hFFFF) cnt_model[i] = cnt_model[i] + 16'd1;
      end
    end

    // Halt request latency with a bounded wait.
    do_reset();
    @(posedge clk); #1; action = 4'b0100; match_m = 4'b0100; valid_m = 1;
    @(posedge clk); #1; match_m = 0; valid_m = 0;
    seen = 0; lat = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (halt_req_o) begin seen = 1; lat = c; end
      else if (c < 8) begin @(posedge clk); #1; end
    end
    check("halt_req_seen", 64'(seen), 64'd1);
    check("halt_req_latency", 64'(lat), 64'd2);
    @(posedge clk); #1; halt_ack = 1;
    @(posedge clk); #1; halt_ack = 0;
    @(negedge clk);
    check("halt_req_after_ack", 64'(halt_req_o), 64'd0);
    halt_done = 1;
    @(posedge clk); #1; halt_done = 0;

`ifdef LSU_TRIG_HITCNT_EN
    // Saturation of counter 0.
    do_reset();
    @(posedge clk); #1; action = 0; match_m = 4'b0001; valid_m = 1;
    for (int c = 0; c < 65540; c++) @(posedge clk);
    #1; match_m = 0; valid_m = 0;
    @(posedge clk); @(negedge clk);
    check("hitcnt_saturated", 64'(hitcnt_o[15:0]), 64'h0000_0000_0000_FFFF);
    @(posedge clk); #1; match_m = 4'b0001; valid_m = 1;
    @(posedge clk); #1; match_m = 0; valid_m = 0;
    @(posedge clk); @(negedge clk);
    check("hitcnt_sat_hold", 64'(hitcnt_o[15:0]), 64'h0000_0000_0000_FFFF);
    @(posedge clk); #1; hit_ack = 4'b0001;
    @(posedge clk); #1; hit_ack = 0;
    @(negedge clk);
    check("hitcnt_ack_clear", 64'(hitcnt_o[15:0]), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
